// File: rtl/cci_mpf_prim_fifo_arb_pkg.sv
// Shared types for the multi-requester FIFO enqueue arbiter.
package cci_mpf_prim_fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } t_fifo_enq_arb_state;

endpackage

// File: rtl/cci_mpf_prim_rr_arb.sv
// Combinational round-robin picker: priority starts just after last_grant.
module cci_mpf_prim_rr_arb #(
    parameter int N_REQ = 4,
    localparam int N_ID_BITS = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]     req,
    input  logic [N_ID_BITS-1:0] last_grant,
    output logic                 grant_valid,
    output logic [N_ID_BITS-1:0] grant_idx
);

    // Scan farthest-to-nearest so the nearest requester after last_grant wins.
    always_comb begin
        int j;
        j = 0;
        grant_valid = 1'b0;
        grant_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = (int'(last_grant) + i) % N_REQ;
            if (req[j]) begin
                grant_valid = 1'b1;
                grant_idx = N_ID_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/cci_mpf_prim_fifo_enq_arb.sv
// Packet-atomic round-robin arbiter feeding a single shared FIFO.
module cci_mpf_prim_fifo_enq_arb
    import cci_mpf_prim_fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int N_DATA_BITS = 32,
    localparam int N_ID_BITS = $clog2(N_REQ)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ-1:0][N_DATA_BITS-1:0]    req_data,
    input  logic [N_REQ-1:0]                     req_eop,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [N_ID_BITS+N_DATA_BITS-1:0]     enq_data,
    output logic                                 enq_en,
    input  logic                                 fifo_notFull,
    input  logic                                 fifo_almostFull,
    output logic                                 locked
);

    t_fifo_enq_arb_state state, state_next;
    logic [N_ID_BITS-1:0] owner, owner_next;
    logic [N_ID_BITS-1:0] last_grant, last_grant_next;

    logic                 rr_valid;
    logic [N_ID_BITS-1:0] rr_idx;
    logic                 gnt_valid;
    logic [N_ID_BITS-1:0] gnt_idx;
    logic                 accept;

    cci_mpf_prim_rr_arb #(
        .N_REQ(N_REQ)
    ) rr (
        .req(req_valid),
        .last_grant(last_grant),
        .grant_valid(rr_valid),
        .grant_idx(rr_idx)
    );

    // While locked only the owner may be granted, even when it stalls.
    always_comb begin
        gnt_valid = rr_valid;
        gnt_idx = rr_idx;
        if (state == LOCKED) begin
            gnt_valid = req_valid[owner];
            gnt_idx = owner;
        end
    end

    assign accept = gnt_valid && !fifo_almostFull && !reset;
    assign req_ready = accept ? (N_REQ'(1) << gnt_idx) : '0;
    assign locked = (state == LOCKED);

    always_comb begin
        state_next = state;
        owner_next = owner;
        last_grant_next = last_grant;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (req_eop[gnt_idx]) begin
                        last_grant_next = gnt_idx;
                    end else begin
                        state_next = LOCKED;
                        owner_next = gnt_idx;
                    end
                end
                LOCKED: begin
                    if (req_eop[owner]) begin
                        state_next = IDLE;
                        last_grant_next = owner;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last_grant <= N_ID_BITS'(N_REQ - 1);
        end else begin
            state <= state_next;
            owner <= owner_next;
            last_grant <= last_grant_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_en <= 1'b0;
            enq_data <= '0;
        end else begin
            enq_en <= accept;
            if (accept) begin
                enq_data <= {gnt_idx, req_data[gnt_idx]};
            end
        end
    end

    // almostFull threshold >= 2 must keep a registered write from hitting a full FIFO.
    a_no_enq_when_full: assert property (
        @(posedge clk) disable iff (reset) !(enq_en && !fifo_notFull)
    ) else $fatal(1, "enq_en asserted while FIFO full");

endmodule

// File: doc/cci_mpf_prim_fifo_enq_arb.md
CCI_MPF_PRIM_FIFO_ENQ_ARB -- requirements
Module: cci_mpf_prim_fifo_enq_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, minimum 2.
REQ-002 SHALL have parameter N_DATA_BITS, default 32: payload width per beat.
REQ-003 SHALL define localparam N_ID_BITS = $clog2(N_REQ).
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ: per-requester beat valid.
REQ-007 SHALL have port req_data, input, N_REQ x N_DATA_BITS: per-requester beat payload.
REQ-008 SHALL have port req_eop, input, N_REQ: per-requester last beat of packet.
REQ-009 SHALL have port req_ready, output, N_REQ: beat accepted when valid and ready are both high.
REQ-010 SHALL have port enq_data, output, N_ID_BITS+N_DATA_BITS: {source id, payload} to the shared FIFO.
REQ-011 SHALL have port enq_en, output, 1: FIFO write strobe.
REQ-012 SHALL have port fifo_notFull, input, 1: FIFO not full.
REQ-013 SHALL have port fifo_almostFull, input, 1: FIFO almost full; the FIFO threshold SHALL be at least 2.
REQ-014 SHALL have port locked, output, 1: a packet is in progress.

Function
REQ-015 SHALL accept at most one beat per cycle across all requesters.
REQ-016 SHALL register the accepted beat: enq_en and enq_data are driven one cycle after acceptance, giving 1-cycle latency.
REQ-017 SHALL drive req_ready combinationally: the bit is high only for the current grantee, and only when fifo_almostFull is 0.
REQ-018 SHALL run a two-state FSM.
- IDLE: grant by round-robin among requesters with req_valid high.
- LOCKED: grant only the lock owner.
REQ-019 SHALL set round-robin priority to start at (last_grant+1) mod N_REQ, wrapping from N_REQ-1 to 0.
REQ-020 SHALL handle acceptance in IDLE as follows:
- eop=1: remain IDLE and set last_grant to the grantee.
- eop=0: go to LOCKED with owner = grantee.
REQ-021 SHALL, on acceptance of the owner's eop=1 beat in LOCKED, return to IDLE and set last_grant to the owner.
REQ-022 SHALL, in LOCKED while the owner drops req_valid, hold the lock and grant no other requester.
REQ-023 SHALL, when fifo_almostFull is asserted, accept nothing, preserve the state and owner, and leave last_grant unchanged.
REQ-024 SHALL change neither state nor last_grant in any cycle with no acceptance.
REQ-025 SHALL drive locked high exactly while the state is LOCKED.
REQ-026 SHALL never assert enq_en in a cycle where fifo_notFull is 0; simulation SHALL $fatal on violation.
REQ-027 SHALL set enq_data[N_ID_BITS+N_DATA_BITS-1 : N_DATA_BITS] to the grantee index of the accepted beat.

Reset
REQ-028 SHALL, on asynchronous reset assertion, immediately force:
- enq_en = 0
- enq_data = 0
- state = IDLE
- owner = 0
- last_grant = N_REQ-1, so requester 0 has first priority
REQ-029 SHALL hold req_ready all-zero and locked = 0 while reset is high.
REQ-030 SHALL, on reset mid-packet, drop the partial packet lock and restart in IDLE; beats already enqueued are not recalled.
REQ-031 SHALL be able to accept a beat on the first clock edge after reset deasserts.

Structure
REQ-032 SHALL place the FSM enum t_fifo_enq_arb_state (IDLE, LOCKED) in package cci_mpf_prim_fifo_arb_pkg.
REQ-033 SHALL implement the combinational round-robin picker as sub-module cci_mpf_prim_rr_arb, with:
- parameter N_REQ
- inputs: request vector, last_grant
- outputs: grant_valid, grant_idx
REQ-034 SHALL keep the FIFO itself outside this block and connect it to the enq_* and fifo_* ports.

Verification
REQ-035 SHALL cover fairness: N_REQ=4, all four requesters hold single-beat packets valid for 8 cycles -> enq_data ids 0,1,2,3,0,1,2,3 on consecutive cycles starting one cycle after the first acceptance.
REQ-036 SHALL cover packet lock: requester 2 sends a 3-beat packet while requester 1 is valid -> ids 2,2,2 are enqueued contiguously, locked is high for 2 cycles, then id 1 follows.
REQ-037 SHALL cover backpressure: fifo_almostFull is raised mid-packet after beat 1 for 5 cycles -> req_ready is all-zero and enq_en stays 0 for those cycles (after the pipeline drains), and beats 2..3 resume from the same owner.
REQ-038 SHALL cover owner gap: the lock owner drops valid for 4 cycles while others are valid -> no other id is enqueued until the owner's eop is accepted.
REQ-039 SHALL cover async reset: reset is asserted mid-cycle during LOCKED -> enq_en is 0 and locked is 0 before the next edge, and the next grant after release goes to requester 0 if it is valid.
REQ-040 SHALL cover wrap-around: last_grant=3 and requesters 0 and 3 are valid -> requester 0 is granted first.
